param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 110 +++++++++++
 tb/tb_param_counter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
//
// Up/down counter over the inclusive range 0..limit with selectable wrap or
// saturate behaviour at the range boundaries, a synchronous clamped load,
// a one-cycle terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   RESET_VAL  value placed in count on reset (not clamped to limit)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         count enable, one step per enabled cycle
//   up_dn      direction: 1 = increment, 0 = decrement
//   sat_mode   boundary behaviour: 1 = saturate, 0 = wrap
//   load       synchronous load strobe (beats en)
//   load_val   value to load, clamped to limit
//   limit      inclusive upper bound of the count range
//   clr_ovf    clears the sticky overflow flag (a same-edge boundary wins)
//   count      registered counter value
//   tc         registered pulse, high the cycle after each boundary event
//   ovf        registered sticky flag, set by any boundary event
// ---------------------------------------------------------------------------
module param_counter #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_next;

  // Boundary detection. The up test uses >= so that lowering limit below
  // the current count at runtime is treated as reaching the top.
  logic at_top;
  logic at_bottom;
  logic up_event;
  logic dn_event;
  logic boundary;

  assign at_top    = (count >= limit);
  assign at_bottom = (count == '0);
  // A load takes precedence over en, so no boundary can occur on a load edge.
  assign up_event  = !load && en &&  up_dn && at_top;
  assign dn_event  = !load && en && !up_dn && at_bottom;
  assign boundary  = up_event || dn_event;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    tc_next    = 1'b0;

    if (load) begin
      count_next = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (up_event) begin
        count_next = sat_mode ? limit : '0;
        tc_next    = 1'b1;
      end else if (dn_event) begin
        count_next = sat_mode ? '0 : limit;
        tc_next    = 1'b1;
      end else if (up_dn) begin
        count_next = count + 1'b1;
      end else begin
        count_next = count - 1'b1;
      end
    end
  end

  // Set beats clear when both happen on the same edge.
  always_comb begin
    ovf_next = ovf;
    if (boundary) begin
      ovf_next = 1'b1;
    end else if (clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= tc_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// ---------------------------------------------------------------------------
// tb_param_counter
//
// Directed bench for param_counter (WIDTH = 4, RESET_VAL = 0). Each task
// drives one scenario and compares count/tc/ovf against hand-computed
// values one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_param_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         sat_mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  param_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are stable #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b0; load_val = '0; clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    limit = 4'd15;
    rst = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; clr_ovf = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d tc=%b ovf=%b, required count=0 tc=0 ovf=0", count, tc, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [W-1:0] exp_c;
    logic         exp_tc;
    logic         exp_ovf;
    do_reset();
    limit = 4'd15; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_c   = W'(i + 1);
      exp_tc  = (i == 15);
      exp_ovf = (i >= 15);
      checks++;
      if (count !== exp_c || tc !== exp_tc || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b ovf=%b, required count=%0d tc=%b ovf=%b",
                 i, count, tc, ovf, exp_c, exp_tc, exp_ovf);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_modulus();
    logic [W-1:0] exp_c;
    logic         exp_tc;
    do_reset();
    limit = 4'd9; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    // 11 steps: 1..9, 0, 1; then 2..5.
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_c  = (i < 9) ? W'(i + 1) : (i == 9) ? 4'd0 : W'(i - 9);
      exp_tc = (i == 9);
      checks++;
      if (count !== exp_c || tc !== exp_tc) begin
        errors++;
        $display("FAIL modulus[%0d]: count=%0d tc=%b, required count=%0d tc=%b",
                 i, count, tc, exp_c, exp_tc);
      end
    end
    // count is 5; lowering limit to 3 makes the next up step a boundary.
    limit = 4'd3;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL modulus_lowered: count=%0d tc=%b, required count=0 tc=1", count, tc);
    end
    en = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL modulus_hold: count=%0d tc=%b, required count=0 tc=0", count, tc);
    end
  endtask

  task automatic test_sat_down();
    logic [W-1:0] exp_c   [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic         exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    limit = 4'd15; load = 1'b1; load_val = 4'd2; sat_mode = 1'b0;
    tick();
    load = 1'b0; sat_mode = 1'b1; up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || tc !== exp_tc[i] || ovf !== exp_ovf[i]) begin
        errors++;
        $display("FAIL sat_down[%0d]: count=%0d tc=%b ovf=%b, required count=%0d tc=%b ovf=%b",
                 i, count, tc, ovf, exp_c[i], exp_tc[i], exp_ovf[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_up_and_wrap_down();
    do_reset();
    limit = 4'd9; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
    tick();
    checks++;
    if (count !== 4'd9 || tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_up_step: count=%0d tc=%b, required count=9 tc=0", count, tc);
    end
    tick();
    checks++;
    if (count !== 4'd9 || tc !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_up_hold: count=%0d tc=%b ovf=%b, required count=9 tc=1 ovf=1", count, tc, ovf);
    end
    // Down from 9 once, then load 0 and wrap down to limit.
    up_dn = 1'b0; sat_mode = 1'b0;
    tick();
    checks++;
    if (count !== 4'd8 || tc !== 1'b0) begin
      errors++;
      $display("FAIL dec_step: count=%0d tc=%b, required count=8 tc=0", count, tc);
    end
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd9 || tc !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: count=%0d tc=%b, required count=9 tc=1", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_reset();
    limit = 4'd9; load = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    tick();
    checks++;
    if (count !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d tc=%b ovf=%b, required count=9 tc=0 ovf=0", count, tc, ovf);
    end
    load = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL load_then_wrap: count=%0d tc=%b, required count=0 tc=1", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_flag_race();
    do_reset();
    limit = 4'd9; up_dn = 1'b1; sat_mode = 1'b0;
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    // ovf now 1; reload and wrap again while clearing on the same edge.
    en = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
    tick();
    checks++;
    if (ovf !== 1'b1 || tc !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL flag_race_set_wins: count=%0d tc=%b ovf=%b, required count=0 tc=1 ovf=1", count, tc, ovf);
    end
    en = 1'b0;
    tick();
    checks++;
    if (ovf !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL flag_race_clear: tc=%b ovf=%b, required tc=0 ovf=0", tc, ovf);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    limit = 4'd15; load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    checks++;
    if (count !== 4'd7 || ovf !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_keeps_ovf: count=%0d tc=%b ovf=%b, required count=7 tc=0 ovf=1", count, tc, ovf);
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1; clr_ovf = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d tc=%b ovf=%b, required count=0 tc=0 ovf=0", count, tc, ovf);
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (count !== 4'd1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: count=%0d tc=%b, required count=1 tc=0", count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_limit_zero();
    do_reset();
    limit = 4'd0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL limit0_up: count=%0d tc=%b ovf=%b, required count=0 tc=1 ovf=1", count, tc, ovf);
    end
    up_dn = 1'b0; sat_mode = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL limit0_down: count=%0d tc=%b, required count=0 tc=1", count, tc);
    end
    en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    limit = 4'd15;
    test_reset();
    test_wrap_up();
    test_modulus();
    test_sat_down();
    test_sat_up_and_wrap_down();
    test_load_clamp();
    test_flag_race();
    test_reset_mid();
    test_limit_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
